// File: rtl/delay_sound_timers_pkg.sv
// Shared platform constants and common types for the delay/sound timer block.
// The platform defines are guarded so a board-level build can override them
// with its own values.

`ifndef DELAY_SOUND_TIMERS_PLATFORM_DEFS
`define DELAY_SOUND_TIMERS_PLATFORM_DEFS

`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50000000
`endif

`ifndef TONE_HZ_DEFAULT
`define TONE_HZ_DEFAULT 440
`endif

`endif

package delay_sound_timers_pkg;

    // Both timers are 8 bits wide and tick at 60 Hz
    localparam int unsigned TIMER_W = 8;

    typedef logic [TIMER_W-1:0] timer_t;

    localparam int unsigned DEFAULT_CLK_HZ  = `CLOCK_SPEED;
    localparam int unsigned DEFAULT_TONE_HZ = `TONE_HZ_DEFAULT;

    // Clock cycles per buzzer half-period
    function automatic int unsigned tone_half(input int unsigned clk_hz,
                                              input int unsigned tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/delay_sound_timers_countdown8.sv
// countdown8: 8-bit loadable timer that saturates at zero when decremented
// by the 60 Hz strobe and raises a one-cycle expiry pulse on a tick-driven
// 1 -> 0 transition.

module countdown8
    import delay_sound_timers_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] value,
    output logic       expired
);

    timer_t value_q, value_d;
    logic   expired_q, expired_d;

    // Next-state: a load wins over a coincident tick; zero holds on a tick
    always_comb begin
        value_d   = value_q;
        expired_d = 1'b0;
        if (we) begin
            value_d = wdata;
        end else if (tick && (value_q != '0)) begin
            value_d   = value_q - timer_t'(1);
            // Only a countdown reaching zero counts as expiry, never a load
            expired_d = (value_q == timer_t'(1));
        end
    end

    // Timer and expiry pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            expired_q <= expired_d;
        end
    end

    assign value   = value_q;
    assign expired = expired_q;

endmodule

// File: rtl/delay_sound_timers.sv
// delay_sound_timers: delay timer (DT) and sound timer (ST), each counting
// down at 60 Hz, plus a square-wave buzzer that runs while ST is nonzero.

module delay_sound_timers
    import delay_sound_timers_pkg::*;
#(
    parameter int unsigned CLK_HZ  = `CLOCK_SPEED,
    parameter int unsigned TONE_HZ = DEFAULT_TONE_HZ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_60hz,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_value,
    output logic [7:0] st_value,
    output logic       dt_expired,
    output logic       sound_active,
    output logic       buzzer
);

    // HALF must be at least 1, i.e. CLK_HZ >= 2 * TONE_HZ
    localparam int unsigned HALF = tone_half(CLK_HZ, TONE_HZ);
    localparam int unsigned CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic          st_expired_unused;
    logic [CW-1:0] div_q, div_d;
    logic          buzzer_q, buzzer_d;

    countdown8 u_dt (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_60hz),
        .we      (dt_we),
        .wdata   (wdata),
        .value   (dt_value),
        .expired (dt_expired)
    );

    // The sound timer has no expiry output; its pulse is left unused
    countdown8 u_st (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_60hz),
        .we      (st_we),
        .wdata   (wdata),
        .value   (st_value),
        .expired (st_expired_unused)
    );

    assign sound_active = (st_value != 8'd0);

    // Tone divider next-state: idle forces phase to zero, a reload of ST
    // while active leaves the running phase untouched
    always_comb begin
        div_d    = div_q;
        buzzer_d = buzzer_q;
        if (!sound_active) begin
            div_d    = '0;
            buzzer_d = 1'b0;
        end else if (div_q == HALF_LAST) begin
            div_d    = '0;
            buzzer_d = ~buzzer_q;
        end else begin
            div_d = div_q + CW'(1);
        end
    end

    // Tone divider and buzzer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            buzzer_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer = buzzer_q;

endmodule

// File: tb/tb_delay_sound_timers.sv
// Directed bench for delay_sound_timers with CLK_HZ=1000, TONE_HZ=100
// (five clock cycles per buzzer half-period).

module tb_delay_sound_timers;

    logic       clk;
    logic       rst_n;
    logic       tick_60hz;
    logic       dt_we;
    logic       st_we;
    logic [7:0] wdata;
    logic [7:0] dt_value;
    logic [7:0] st_value;
    logic       dt_expired;
    logic       sound_active;
    logic       buzzer;

    int n_total = 0;
    int n_bad   = 0;
    int pulses;

    delay_sound_timers #(
        .CLK_HZ  (1000),
        .TONE_HZ (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_60hz    (tick_60hz),
        .dt_we        (dt_we),
        .st_we        (st_we),
        .wdata        (wdata),
        .dt_value     (dt_value),
        .st_value     (st_value),
        .dt_expired   (dt_expired),
        .sound_active (sound_active),
        .buzzer       (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_step();
        tick_60hz = 1'b1;
        step();
        tick_60hz = 1'b0;
    endtask

    task automatic load(input logic dt, input logic st, input logic [7:0] val);
        dt_we = dt;
        st_we = st;
        wdata = val;
        step();
        dt_we = 1'b0;
        st_we = 1'b0;
        wdata = 8'd0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tick_60hz = 1'b0;
        dt_we     = 1'b0;
        st_we     = 1'b0;
        wdata     = 8'd0;
        step();
        step();
        check("rst_dt", dt_value, 0);
        check("rst_st", st_value, 0);
        check("rst_exp", dt_expired, 0);
        check("rst_snd", sound_active, 0);
        check("rst_buz", buzzer, 0);
        rst_n = 1'b1;
        step();

        // DT countdown 3 -> 0 with single expiry pulse, then saturation
        load(1'b1, 1'b0, 8'd3);
        check("dt_load3", dt_value, 3);
        for (int i = 2; i >= 0; i--) begin
            tick_step();
            check("dt_count", dt_value, i);
            check("dt_count_exp", dt_expired, (i == 0) ? 1 : 0);
        end
        step();
        check("dt_exp_one_cycle", dt_expired, 0);
        tick_step();
        check("dt_sat_val", dt_value, 0);
        check("dt_sat_exp", dt_expired, 0);

        // Load beats coincident tick
        load(1'b1, 1'b0, 8'd5);
        tick_60hz = 1'b1;
        load(1'b1, 1'b0, 8'd9);
        tick_60hz = 1'b0;
        check("dt_load_over_tick", dt_value, 9);

        // Zero load on a 1->0 tick: no pulse; zero load at zero: no pulse
        load(1'b1, 1'b0, 8'd1);
        tick_60hz = 1'b1;
        load(1'b1, 1'b0, 8'd0);
        tick_60hz = 1'b0;
        check("dt_zero_load_val", dt_value, 0);
        check("dt_zero_load_exp", dt_expired, 0);
        step();
        check("dt_zero_load_exp2", dt_expired, 0);
        load(1'b1, 1'b0, 8'd0);
        check("dt_zero_at_zero", dt_expired, 0);

        // Nonzero load on a 1->0 tick suppresses expiry
        load(1'b1, 1'b0, 8'd1);
        tick_60hz = 1'b1;
        load(1'b1, 1'b0, 8'd7);
        tick_60hz = 1'b0;
        check("dt_reload_val", dt_value, 7);
        check("dt_reload_exp", dt_expired, 0);

        // Sound: tone period and stop regardless of phase
        load(1'b0, 1'b1, 8'd2);
        check("st_load2", st_value, 2);
        check("snd_on", sound_active, 1);
        check("buz_start", buzzer, 0);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("buz_wave", buzzer, (i / 5) % 2);
        end
        tick_step();
        check("st_tick1", st_value, 1);
        tick_step();
        check("st_tick0", st_value, 0);
        check("snd_off", sound_active, 0);
        check("buz_lag", buzzer, 1);
        step();
        check("buz_off", buzzer, 0);

        // ST reload mid-tone keeps phase; zero load stops sound
        load(1'b0, 1'b1, 8'd3);
        step();
        step();
        load(1'b0, 1'b1, 8'd7);
        check("st_reload", st_value, 7);
        step();
        check("buz_phase4", buzzer, 0);
        step();
        check("buz_phase5", buzzer, 1);
        load(1'b0, 1'b1, 8'd0);
        check("st_zero_snd", sound_active, 0);
        step();
        check("st_zero_buz", buzzer, 0);

        // Asynchronous reset mid-countdown and mid-tone
        load(1'b1, 1'b1, 8'd10);
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_buz", buzzer, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dt", dt_value, 0);
        check("arst_st", st_value, 0);
        check("arst_exp", dt_expired, 0);
        check("arst_snd", sound_active, 0);
        check("arst_buz", buzzer, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_step();
            check("post_rst_exp", dt_expired, 0);
            check("post_rst_dt", dt_value, 0);
        end
        load(1'b1, 1'b0, 8'd1);
        tick_step();
        check("resume_exp", dt_expired, 1);

        // Joint load of 0x80 and full countdown
        load(1'b1, 1'b1, 8'h80);
        check("both_dt", dt_value, 128);
        check("both_st", st_value, 128);
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            tick_step();
            if (dt_expired) pulses++;
            step();
            if (dt_expired) pulses++;
        end
        check("long_dt", dt_value, 0);
        check("long_st", st_value, 0);
        check("long_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_sound_timers.md
DELAY_SOUND_TIMERS -- requirements
Module: delay_sound_timers

Interface
REQ-001 SHALL have parameter CLK_HZ, default `CLOCK_SPEED: system clock frequency in Hz.
REQ-002 SHALL have parameter TONE_HZ, default 440: buzzer square-wave frequency in Hz.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port tick_60hz  input  1  single-cycle 60 Hz strobe from the timer block.
REQ-006 SHALL have port dt_we  input  1  load delay timer (DT) from wdata.
REQ-007 SHALL have port st_we  input  1  load sound timer (ST) from wdata.
REQ-008 SHALL have port wdata  input  8  load value for DT/ST.
REQ-009 SHALL have port dt_value  output  8  current DT value.
REQ-010 SHALL have port st_value  output  8  current ST value.
REQ-011 SHALL have port dt_expired  output  1  one-cycle pulse when DT reaches 0 by countdown.
REQ-012 SHALL have port sound_active  output  1  high while ST != 0.
REQ-013 SHALL have port buzzer  output  1  square wave at TONE_HZ while sound_active, else 0.

Function
REQ-014 On tick_60hz with DT != 0 and dt_we low, DT SHALL decrement by 1 next edge; ST likewise with st_we.
REQ-015 DT/ST at 0 SHALL hold 0 on tick_60hz; no wrap to 255.
REQ-016 dt_we SHALL load wdata into DT next edge, taking priority over a coincident tick (no decrement that cycle); st_we likewise for ST.
REQ-017 dt_we and st_we together SHALL load wdata into both.
REQ-018 Loading 0 SHALL stop the timer immediately; a load of 0 SHALL NOT pulse dt_expired.
REQ-019 dt_expired SHALL be a registered pulse, high exactly the cycle dt_value first reads 0 after a tick-driven 1->0 transition.
REQ-020 Loading DT with a nonzero value in the same cycle as a 1->0 tick SHALL suppress dt_expired.
REQ-021 sound_active SHALL equal (st_value != 0), combinational from the ST register.
REQ-022 Tone divider: HALF = CLK_HZ/(2*TONE_HZ); counter width SHALL be $clog2(HALF+1) bits; HALF >= 1 required.
REQ-023 While sound_active low: divider counter SHALL be 0 and buzzer 0 from the next edge.
REQ-024 While sound_active high: counter increments; on reaching HALF-1 it SHALL clear and buzzer SHALL toggle.
REQ-025 Hence first buzzer rise SHALL occur HALF cycles after sound_active rises; buzzer SHALL fall the cycle after sound_active drops, regardless of phase.
REQ-026 Reloading ST with nonzero while sound is active SHALL NOT reset tone phase.
REQ-027 dt_value, st_value, dt_expired, buzzer SHALL be registered outputs.

Reset
REQ-028 rst_n low SHALL asynchronously force DT=0, ST=0, dt_expired=0, divider=0, buzzer=0; hence sound_active=0.
REQ-029 Reset mid-countdown or mid-tone SHALL abort without any dt_expired pulse; operation resumes on the first edge after rst_n rises.

Structure
REQ-030 CLOCK_SPEED SHALL come from the shared platform-specific include; a default TONE_HZ constant SHALL live there too.
REQ-031 One sub-module, countdown8 (8-bit load/saturating-decrement register with expiry pulse), SHALL be instantiated twice for DT and ST; tone divider SHALL be inline.

Verification (CLK_HZ=1000, TONE_HZ=100, so HALF=5)
REQ-032 dt_we, wdata=3; 3 ticks -> dt_value 3,2,1,0; dt_expired high one cycle with dt_value=0; 4th tick -> stays 0, no pulse.
REQ-033 DT=5, dt_we wdata=9 in the same cycle as a tick -> dt_value=9 next cycle, not 4 or 8.
REQ-034 st_we wdata=2 -> sound_active next cycle; buzzer rises 5 cycles later, toggles every 5; after 2 ticks ST=0, buzzer 0 next cycle.
REQ-035 DT=1, tick plus dt_we wdata=0 -> DT=0, no dt_expired; then dt_we wdata=0 at DT=0 -> no pulse.
REQ-036 DT=10, ST=10, buzzer high; assert rst_n low between edges -> all outputs 0 immediately, no expiry pulse after release.
REQ-037 dt_we and st_we together, wdata=0x80 -> both read 128; 128 ticks -> both 0, one dt_expired pulse.
